// File: rtl/rf_alu_sequencer.sv
// Issue/execute/writeback sequencer for a 32x32 register file. It reads rs1/rs2,
// runs one ALU operation and writes the result back to rd.
module rf_alu_sequencer #(
   parameter int ADSize = 5,
   parameter int DASize = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [2:0]        instr_op,
   input  logic [ADSize-1:0] instr_rs1,
   input  logic [ADSize-1:0] instr_rs2,
   input  logic [ADSize-1:0] instr_rd,
   output logic              rf_enable,
   output logic              rf_Read,
   output logic              rf_Write,
   output logic [ADSize-1:0] rf_Read_ADDR_1,
   output logic [ADSize-1:0] rf_Read_ADDR_2,
   output logic [ADSize-1:0] rf_Write_ADDR,
   output logic [DASize-1:0] rf_DIN,
   input  logic [DASize-1:0] rf_OUT_1,
   input  logic [DASize-1:0] rf_OUT_2,
   output logic              done,
   output logic [DASize-1:0] result,
   output logic              flag_carry,
   output logic              flag_zero,
   output logic [2:0]        dbg_state
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      READ = 3'd1,
      WAIT = 3'd2,
      EXEC = 3'd3,
      WB   = 3'd4
   } state_t;

   state_t state, state_next;

   // armed holds instr_ready low during reset and for the first cycle after release.
   logic              armed;
   logic              accept;
   logic [2:0]        op_q;
   logic [ADSize-1:0] rs1_q, rs2_q, rd_q;
   logic [DASize-1:0] opa_q, opb_q;
   logic [DASize-1:0] alu_res;
   logic              alu_carry;
   logic [DASize:0]   alu_sum;

   // Handshake: an operation is taken at a rising edge where instr_valid and
   // instr_ready are both 1; instr_ready is high only while idle and armed.
   assign accept    = (state == IDLE) && armed && instr_valid;
   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         armed      <= 1'b0;
         op_q       <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         rd_q       <= '0;
         opa_q      <= '0;
         opb_q      <= '0;
         result     <= '0;
         flag_carry <= 1'b0;
         flag_zero  <= 1'b0;
      end else begin
         state <= state_next;
         armed <= 1'b1;
         if (accept) begin
            op_q  <= instr_op;
            rs1_q <= instr_rs1;
            rs2_q <= instr_rs2;
            rd_q  <= instr_rd;
         end
         if (state == WAIT) begin
            opa_q <= rf_OUT_1;
            opb_q <= rf_OUT_2;
         end
         if (state == EXEC) begin
            result     <= alu_res;
            flag_carry <= alu_carry;
            flag_zero  <= (alu_res == '0);
         end
      end
   end

   always_comb begin
      state_next     = state;
      instr_ready    = 1'b0;
      rf_enable      = 1'b0;
      rf_Read        = 1'b0;
      rf_Write       = 1'b0;
      rf_Read_ADDR_1 = '0;
      rf_Read_ADDR_2 = '0;
      rf_Write_ADDR  = '0;
      rf_DIN         = '0;
      done           = 1'b0;
      case (state)
         IDLE: begin
            instr_ready = armed;
            if (accept) state_next = READ;
         end
         READ: begin
            rf_enable      = 1'b1;
            rf_Read        = 1'b1;
            rf_Read_ADDR_1 = rs1_q;
            rf_Read_ADDR_2 = rs2_q;
            state_next     = WAIT;
         end
         WAIT: state_next = EXEC;
         EXEC: state_next = WB;
         WB: begin
            rf_enable     = 1'b1;
            rf_Write      = 1'b1;
            rf_Write_ADDR = rd_q;
            rf_DIN        = result;
            done          = 1'b1;
            state_next    = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Carry is the unsigned overflow for ADD and the borrow for SUB.
   always_comb begin
      alu_res   = '0;
      alu_carry = 1'b0;
      alu_sum   = {1'b0, opa_q} + {1'b0, opb_q};
      case (op_q)
         3'd0: begin
            alu_res   = alu_sum[DASize-1:0];
            alu_carry = alu_sum[DASize];
         end
         3'd1: begin
            alu_res   = opa_q - opb_q;
            alu_carry = (opa_q < opb_q);
         end
         3'd2: alu_res = opa_q & opb_q;
         3'd3: alu_res = opa_q | opb_q;
         3'd4: alu_res = opa_q ^ opb_q;
         3'd5: alu_res = opa_q << opb_q[4:0];
         3'd6: alu_res = opa_q >> opb_q[4:0];
         3'd7: alu_res = {{(DASize-1){1'b0}}, ($signed(opa_q) < $signed(opb_q))};
         default: alu_res = '0;
      endcase
   end

endmodule

// File: tb/tb_rf_alu_sequencer.sv
// Bench for rf_alu_sequencer with a behavioural 32x32 register file (registered
// reads, edge-committed writes) and a writeback scoreboard.
module tb_rf_alu_sequencer;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int EW = AW + DW + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          instr_valid;
  logic          instr_ready;
  logic [2:0]    instr_op;
  logic [AW-1:0] instr_rs1, instr_rs2, instr_rd;
  logic          rf_enable, rf_Read, rf_Write;
  logic [AW-1:0] rf_Read_ADDR_1, rf_Read_ADDR_2, rf_Write_ADDR;
  logic [DW-1:0] rf_DIN, rf_OUT_1, rf_OUT_2;
  logic          done;
  logic [DW-1:0] result;
  logic          flag_carry, flag_zero;
  logic [2:0]    dbg_state;

  always #5 clk = ~clk;

  rf_alu_sequencer #(.ADSize(AW), .DASize(DW)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
    .instr_rs1(instr_rs1), .instr_rs2(instr_rs2), .instr_rd(instr_rd),
    .rf_enable(rf_enable), .rf_Read(rf_Read), .rf_Write(rf_Write),
    .rf_Read_ADDR_1(rf_Read_ADDR_1), .rf_Read_ADDR_2(rf_Read_ADDR_2),
    .rf_Write_ADDR(rf_Write_ADDR), .rf_DIN(rf_DIN),
    .rf_OUT_1(rf_OUT_1), .rf_OUT_2(rf_OUT_2),
    .done(done), .result(result), .flag_carry(flag_carry), .flag_zero(flag_zero),
    .dbg_state(dbg_state)
  );

  // register file model, with a bench-side preload port
  logic [DW-1:0] rf_mem [32];
  logic          pl_we;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;

  always @(posedge clk) begin
    if (rf_enable && rf_Read) begin
      rf_OUT_1 <= rf_mem[rf_Read_ADDR_1];
      rf_OUT_2 <= rf_mem[rf_Read_ADDR_2];
    end
    if (pl_we) rf_mem[pl_addr] <= pl_data;
    else if (rf_enable && rf_Write) rf_mem[rf_Write_ADDR] <= rf_DIN;
  end

  // scoreboard
  logic [DW-1:0] shadow [32];
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_e;
  int n_checks = 0;
  int n_pass = 0;
  int n_writes = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [DW:0] alu_model(input logic [2:0] op, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
    logic [DW:0] s;
    s = '0;
    case (op)
      3'd0: s = {1'b0, a} + {1'b0, b};
      3'd1: s = {(a < b), a - b};
      3'd2: s[DW-1:0] = a & b;
      3'd3: s[DW-1:0] = a | b;
      3'd4: s[DW-1:0] = a ^ b;
      3'd5: s[DW-1:0] = a << b[4:0];
      3'd6: s[DW-1:0] = a >> b[4:0];
      default: s[0] = ($signed(a) < $signed(b));
    endcase
    return s;
  endfunction

  task automatic push_exp(input logic [2:0] op, input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                          input logic [AW-1:0] d);
    logic [DW:0] m;
    m = alu_model(op, shadow[s1], shadow[s2]);
    exp_q.push_back({d, m[DW-1:0], m[DW], (m[DW-1:0] == '0)});
    shadow[d] = m[DW-1:0];
  endtask

  always @(negedge clk) begin
    if (rst && (rf_Write || done)) begin
      check("done_with_write", {31'd0, done}, {31'd0, rf_Write});
      check("wb_enable", {31'd0, rf_enable}, {31'd0, rf_Write});
    end
    if (rf_Write) begin
      n_writes++;
      if (exp_q.size() == 0) check("unexpected_write", {31'd0, rf_Write}, 32'd0);
      else begin
        exp_e = exp_q.pop_front();
        check("wb_addr", {27'd0, rf_Write_ADDR}, {27'd0, exp_e[EW-1 -: AW]});
        check("wb_din", rf_DIN, exp_e[DW+1:2]);
        check("wb_result", result, exp_e[DW+1:2]);
        check("wb_carry", {31'd0, flag_carry}, {31'd0, exp_e[1]});
        check("wb_zero", {31'd0, flag_zero}, {31'd0, exp_e[0]});
      end
    end
  end

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_we = 1'b1; pl_addr = a; pl_data = d; shadow[a] = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!instr_ready && n < 40) begin @(negedge clk); n++; end
    if (!instr_ready) check("ready_timeout", {31'd0, instr_ready}, 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !instr_ready) && n < 40) begin @(negedge clk); n++; end
    check("drain", exp_q.size(), 32'd0);
  endtask

  task automatic issue(input logic [2:0] op, input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                       input logic [AW-1:0] d, input bit push);
    wait_ready();
    instr_valid = 1'b1; instr_op = op; instr_rs1 = s1; instr_rs2 = s2; instr_rd = d;
    if (push) push_exp(op, s1, s2, d);
    @(negedge clk);
    instr_valid = 1'b0;
    instr_op = 3'($urandom); instr_rs1 = 5'($urandom); instr_rs2 = 5'($urandom);
    instr_rd = 5'($urandom);
    check("read_strobe", {30'd0, rf_enable, rf_Read}, 32'd3);
    check("read_addr1", {27'd0, rf_Read_ADDR_1}, {27'd0, s1});
    check("read_addr2", {27'd0, rf_Read_ADDR_2}, {27'd0, s2});
    check("ready_busy", {31'd0, instr_ready}, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst = 1'b0; instr_valid = 1'b1; instr_op = 3'd0;
    instr_rs1 = 5'd1; instr_rs2 = 5'd2; instr_rd = 5'd3;
    pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, instr_ready}, 32'd0);
    check("rst_strobes", {29'd0, rf_enable, rf_Read, rf_Write}, 32'd0);
    check("rst_addrs", {17'd0, rf_Read_ADDR_1, rf_Read_ADDR_2, rf_Write_ADDR}, 32'd0);
    check("rst_din", rf_DIN, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_flags", {30'd0, flag_carry, flag_zero}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, 32'd0);

    for (int i = 0; i < 32; i++) load(5'(i), $urandom);
    load(5'd0, 32'd0);          load(5'd1, 32'd2);          load(5'd2, 32'd3);
    load(5'd4, 32'hFFFF_FFFE);  load(5'd7, 32'h8000_0000);  load(5'd10, 32'hFFFF_FFFF);
    load(5'd11, 32'd1);
    check("rst_no_accept", {29'd0, dbg_state}, 32'd0);

    instr_valid = 1'b0; rst = 1'b1;
    check("release_ready_low", {31'd0, instr_ready}, 32'd0);
    @(negedge clk);
    check("release_ready_high", {31'd0, instr_ready}, 32'd1);

    issue(3'd0, 5'd1, 5'd2, 5'd5, 1'b1);
    drain();
    check("add_r5", rf_mem[5], 32'd5);
    issue(3'd1, 5'd1, 5'd2, 5'd6, 1'b1);
    issue(3'd1, 5'd3, 5'd3, 5'd12, 1'b1);
    issue(3'd0, 5'd10, 5'd11, 5'd13, 1'b1);
    issue(3'd7, 5'd4, 5'd1, 5'd14, 1'b1);
    issue(3'd6, 5'd7, 5'd1, 5'd15, 1'b1);
    issue(3'd5, 5'd7, 5'd1, 5'd16, 1'b1);
    issue(3'd2, 5'd20, 5'd21, 5'd17, 1'b1);
    issue(3'd3, 5'd22, 5'd23, 5'd18, 1'b1);
    issue(3'd4, 5'd24, 5'd25, 5'd19, 1'b1);
    drain();
    check("sub_r6", rf_mem[6], 32'hFFFF_FFFF);
    check("sub_zero_r12", rf_mem[12], 32'd0);
    check("add_wrap_r13", rf_mem[13], 32'd0);
    check("slt_r14", rf_mem[14], 32'd1);
    check("srl_r15", rf_mem[15], 32'h2000_0000);
    check("sll_r16", rf_mem[16], 32'd0);
    check("result_held", result, shadow[19]);

    // back-to-back with instr_valid held high
    wait_ready();
    instr_valid = 1'b1; instr_op = 3'd0; instr_rs1 = 5'd1; instr_rs2 = 5'd1; instr_rd = 5'd1;
    push_exp(3'd0, 5'd1, 5'd1, 5'd1);
    @(negedge clk);
    instr_rs1 = 5'd1; instr_rs2 = 5'd0; instr_rd = 5'd8;
    for (int i = 0; i < 4; i++) begin
      check("b2b_ready_low", {31'd0, instr_ready}, 32'd0);
      @(negedge clk);
    end
    check("b2b_ready_high", {31'd0, instr_ready}, 32'd1);
    push_exp(3'd0, 5'd1, 5'd0, 5'd8);
    @(negedge clk);
    instr_valid = 1'b0;
    check("b2b_second_read", {29'd0, dbg_state}, 32'd1);
    drain();
    check("b2b_r1", rf_mem[1], 32'd4);
    check("b2b_r8", rf_mem[8], 32'd4);

    // reset during EXEC aborts the writeback
    load(5'd9, 32'h55);
    issue(3'd4, 5'd2, 5'd3, 5'd9, 1'b0);
    repeat (2) @(negedge clk);
    check("abort_in_exec", {29'd0, dbg_state}, 32'd3);
    w = n_writes;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("abort_state", {29'd0, dbg_state}, 32'd0);
    check("abort_outputs", {28'd0, rf_enable, rf_Write, done, instr_ready}, 32'd0);
    repeat (4) @(negedge clk);
    check("abort_no_write", n_writes, w);
    check("abort_r9", rf_mem[9], 32'h55);
    check("abort_idle", {29'd0, dbg_state}, 32'd0);
    check("abort_ready", {31'd0, instr_ready}, 32'd1);

    // random operations, including rd equal to a source and address 0
    for (int i = 0; i < 40; i++)
      issue(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), 1'b1);
    drain();
    for (int i = 0; i < 32; i++) check("final_rf", rf_mem[i], shadow[i]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
